reg_scan_reader: RTL
====================

// Module: reg_scan_reader
// PURPOSE
//   Debug-side reader for the CPU register file. On a start request it walks an
//   address range through one register-file read port (address out, combinational
//   data back). It streams each word with its address to a sink over valid/ready.
//   Sits beside the register file in the top level, on a spare read port, and
//   feeds the board display / debug link.
// PARAMETERS
//   WORD_WIDTH     32  width of one register word
//   ADDRESS_WIDTH  5   register address width; 2**ADDRESS_WIDTH registers
// PORTS
//   clk         in   1              rising-edge clock
//   rst_n       in   1              asynchronous, active-low reset
//   start       in   1              begin scan; sampled only in IDLE
//   abort       in   1              cancel scan; sampled in FETCH/SEND
//   first_addr  in   ADDRESS_WIDTH  first register to read, sampled with start
//   last_addr   in   ADDRESS_WIDTH  last register to read, sampled with start
//   RA          out  ADDRESS_WIDTH  read address to register-file read port
//   RD          in   WORD_WIDTH     combinational read data for RA
//   out_valid   out  1              out_data/out_addr hold a word
//   out_ready   in   1              sink accepts word when high with out_valid
//   out_data    out  WORD_WIDTH     register value
//   out_addr    out  ADDRESS_WIDTH  register index of out_data
//   busy        out  1              high in FETCH or SEND
//   done        out  1              one-cycle pulse after last word accepted
// BEHAVIOUR
// - Reset (rst_n low, async): state IDLE.
//   - RA, out_data, out_addr, last register = 0.
//   - out_valid, busy, done = 0.
// - RA = current address register at all times (registered, glitch-free).
// - FSM states: IDLE, FETCH, SEND. All transitions on rising clk edge.
// - IDLE, start=1:
//   - cur <= first_addr; last <= last_addr; go to FETCH.
//   - start in other states is ignored.
// - FETCH, abort=0:
//   - out_data <= RD; out_addr <= cur; out_valid <= 1; go to SEND.
// - SEND, out_valid held until out_valid & out_ready:
//   - if cur == last: out_valid <= 0; done <= 1 for one cycle; go to IDLE.
//   - else: cur <= cur+1 mod 2**ADDRESS_WIDTH; out_valid <= 0; go to FETCH.
// - out_data/out_addr stable while out_valid=1 and out_ready=0.
// - Latency: start sampled at edge N -> out_valid high after edge N+1.
//   - Steady throughput: one word per 2 cycles with out_ready tied high.
// - Wrap: first_addr > last_addr scans first..max, then 0..last.
//   - first_addr == last_addr sends exactly one word.
// - Coherency: each word is the RD value at its FETCH edge.
//   - A register-file write on the same edge is not seen; whole-file snapshot not
//     guaranteed.
// - abort=1 in FETCH or SEND: next edge -> IDLE, out_valid=0, done stays 0.
//   - abort has priority over the handshake in the same cycle.
//   - A word in SEND that is handshaked in the abort cycle counts as not delivered.
// - done and a new start: done pulses in IDLE; a start in that same cycle is
//   accepted.
// - Reset asserted mid-scan: immediate return to reset values, no done pulse.
// - busy = (state != IDLE).
// TESTING
// - Full scan 0..31, out_ready=1, reg[i]=i*4:
//   -> 32 words in order, out_data=i*4, done after word 31, 64 cycles start-to-done.
// - Single word, first=last=10, reg10=0xDEADBEEF:
//   -> one word addr 10 data 0xDEADBEEF, done pulse, busy low next cycle.
// - Wrap, first=30, last=1:
//   -> out_addr sequence 30,31,0,1, then done.
// - Backpressure, out_ready low 5 cycles on word 3:
//   -> out_valid held, out_data/out_addr unchanged, no skipped or duplicate words.
// - Abort during SEND of word 2, out_ready=1 same cycle:
//   -> IDLE next edge, no done, busy=0.
//   - A new start then rescans from its own first_addr.
// - rst_n low mid-scan (asynchronous, between edges):
//   -> out_valid, busy, RA clear immediately.
//   - start ignored until rst_n high.

Source files
------------

// File: rtl/reg_scan_reader.sv
// Debug-side register-file scanner: walks first..last (with wrap) through one
// read port and streams each word with its address over valid/ready.
module reg_scan_reader #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH-1:0] first_addr,
    input  logic [ADDRESS_WIDTH-1:0] last_addr,
    output logic [ADDRESS_WIDTH-1:0] RA,
    input  logic [WORD_WIDTH-1:0]    RD,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] cur;
    logic [ADDRESS_WIDTH-1:0] cur_nxt;
    logic [ADDRESS_WIDTH-1:0] last;
    logic [ADDRESS_WIDTH-1:0] last_nxt;
    logic [ADDRESS_WIDTH-1:0] out_addr_nxt;
    logic [WORD_WIDTH-1:0]    out_data_nxt;
    logic                     out_valid_nxt;
    logic                     busy_nxt;
    logic                     done_nxt;
    logic                     handshake;
    logic                     at_last;

    assign handshake = out_valid & out_ready;
    assign at_last   = (cur == last);
    assign RA        = cur;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort outranks the handshake
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = abort ? IDLE : SEND;
            SEND: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (handshake) begin
                    state_nxt = at_last ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cur_nxt       = cur;
        last_nxt      = last;
        out_data_nxt  = out_data;
        out_addr_nxt  = out_addr;
        out_valid_nxt = (state_nxt == SEND);
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cur_nxt  = first_addr;
                    last_nxt = last_addr;
                end
            end
            FETCH: begin
                if (!abort) begin
                    out_data_nxt = RD;
                    out_addr_nxt = cur;
                end
            end
            SEND: begin
                if (!abort && handshake) begin
                    if (at_last) begin
                        done_nxt = 1'b1;
                    end else begin
                        cur_nxt = cur + ADDRESS_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= '0;
            last      <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur       <= cur_nxt;
            last      <= last_nxt;
            out_data  <= out_data_nxt;
            out_addr  <= out_addr_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

endmodule
